// File: rtl/bus_control_multi.sv
// 68000 bus controller with programmable chip-select regions, a power-on reset
// sequencer, an unmapped-access watchdog, read-only write BERR and single-step DTACK gating.
module bus_control_multi #(
    parameter int unsigned                  NUM_CS       = 4,
    parameter int unsigned                  ADDR_WIDTH   = 24,
    parameter int unsigned                  WAIT_WIDTH   = 4,
    parameter logic [NUM_CS*ADDR_WIDTH-1:0] CS_BASE      = {24'h180000, 24'h100000, 24'h080000, 24'h000000},
    parameter logic [NUM_CS*ADDR_WIDTH-1:0] CS_MASK      = {4{24'hF80000}},
    parameter logic [NUM_CS*WAIT_WIDTH-1:0] CS_WAIT      = {4'd0, 4'd0, 4'd2, 4'd2},
    parameter logic [NUM_CS-1:0]            CS_RO        = 4'b0011,
    parameter int unsigned                  RESET_CYCLES = 128,
    parameter int unsigned                  BERR_TIMEOUT = 64
) (
    input  logic                  CPUCLK_IN,
    input  logic                  RESET_IN,
    input  logic                  AS_IN,
    input  logic                  RW_IN,
    input  logic                  UDS_IN,
    input  logic                  LDS_IN,
    input  logic [ADDR_WIDTH-1:0] ADDR_IN,
    input  logic                  STEPEN_IN,
    input  logic                  STEP_IN,
    output logic                  RESET,
    output logic                  HALT,
    output logic                  RUN,
    output logic                  DTACK,
    output logic                  BERR,
    output logic [NUM_CS-1:0]     CS,
    output logic                  OE,
    output logic                  UWE,
    output logic                  LWE
);

    localparam int unsigned HCNT_W = $clog2(RESET_CYCLES + 1);
    localparam int unsigned TCNT_W = $clog2(BERR_TIMEOUT + 1);
    localparam int unsigned SEL_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;

    typedef enum logic [2:0] {
        S_HOLD,
        S_IDLE,
        S_WAIT,
        S_STEP,
        S_ACK,
        S_TMO,
        S_ERR
    } state_t;

    state_t                state, state_d;
    logic [HCNT_W-1:0]     hcnt, hcnt_d;
    logic [WAIT_WIDTH-1:0] wcnt, wcnt_d;
    logic [TCNT_W-1:0]     tcnt, tcnt_d;
    logic [SEL_W-1:0]      sel, sel_d;
    logic                  rd, rd_d;
    logic                  uds_q, uds_d;
    logic                  lds_q, lds_d;
    logic                  step_cur, step_prev, step_rise;

    logic                  hit, hit_ro;
    logic [SEL_W-1:0]      hit_idx;
    logic [WAIT_WIDTH-1:0] hit_wait;

    logic                  reset_d, run_d, dtack_d, berr_d, oe_d, uwe_d, lwe_d;
    logic [NUM_CS-1:0]     cs_d;

    assign step_rise = step_cur & ~step_prev;

    // Region decode; scanning from the top down lets the lowest hitting index win.
    always_comb begin
        hit      = 1'b0;
        hit_ro   = 1'b0;
        hit_idx  = '0;
        hit_wait = '0;
        for (int i = int'(NUM_CS) - 1; i >= 0; i--) begin
            if ((ADDR_IN & CS_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) == CS_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
                hit      = 1'b1;
                hit_ro   = CS_RO[i];
                hit_idx  = SEL_W'(i);
                hit_wait = CS_WAIT[i*WAIT_WIDTH +: WAIT_WIDTH];
            end
        end
    end

    // Next-state logic plus output decode of the next state.
    always_comb begin
        state_d = state;
        hcnt_d  = hcnt;
        wcnt_d  = wcnt;
        tcnt_d  = tcnt;
        sel_d   = sel;
        rd_d    = rd;
        uds_d   = uds_q;
        lds_d   = lds_q;

        case (state)
            S_HOLD: begin
                if (hcnt == '0) state_d = S_IDLE;
                else            hcnt_d  = hcnt - HCNT_W'(1);
            end
            S_IDLE: begin
                if (AS_IN && (UDS_IN || LDS_IN)) begin
                    sel_d = hit_idx;
                    rd_d  = RW_IN;
                    uds_d = UDS_IN;
                    lds_d = LDS_IN;
                    if (!hit) begin
                        state_d = S_TMO;
                        tcnt_d  = TCNT_W'(BERR_TIMEOUT - 2);
                    end else if (hit_ro && !RW_IN) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_WAIT;
                        wcnt_d  = hit_wait;
                    end
                end
            end
            S_WAIT: begin
                if (!AS_IN)              state_d = S_IDLE;
                else if (wcnt != '0)     wcnt_d  = wcnt - WAIT_WIDTH'(1);
                else if (STEPEN_IN)      state_d = S_STEP;
                else                     state_d = S_ACK;
            end
            S_STEP: begin
                if (!AS_IN)                       state_d = S_IDLE;
                else if (step_rise || !STEPEN_IN) state_d = S_ACK;
            end
            S_ACK: begin
                if (!AS_IN) state_d = S_IDLE;
            end
            S_TMO: begin
                if (!AS_IN)          state_d = S_IDLE;
                else if (tcnt != '0) tcnt_d  = tcnt - TCNT_W'(1);
                else                 state_d = S_ERR;
            end
            S_ERR: begin
                if (!AS_IN) state_d = S_IDLE;
            end
            default: state_d = S_HOLD;
        endcase

        reset_d = (state_d == S_HOLD);
        run_d   = (state_d != S_HOLD) && (state_d != S_STEP);
        dtack_d = (state_d == S_ACK);
        berr_d  = (state_d == S_ERR);
        cs_d    = '0;
        oe_d    = 1'b0;
        uwe_d   = 1'b0;
        lwe_d   = 1'b0;
        if ((state_d == S_WAIT) || (state_d == S_STEP) || (state_d == S_ACK)) begin
            cs_d  = NUM_CS'(1) << sel_d;
            oe_d  = rd_d;
            uwe_d = !rd_d && uds_d;
            lwe_d = !rd_d && lds_d;
        end
    end

    // State, counters and latched cycle attributes.
    always_ff @(posedge CPUCLK_IN) begin
        if (RESET_IN) begin
            state     <= S_HOLD;
            hcnt      <= HCNT_W'(RESET_CYCLES - 1);
            wcnt      <= '0;
            tcnt      <= '0;
            sel       <= '0;
            rd        <= 1'b0;
            uds_q     <= 1'b0;
            lds_q     <= 1'b0;
            step_cur  <= 1'b0;
            step_prev <= 1'b0;
        end else begin
            state     <= state_d;
            hcnt      <= hcnt_d;
            wcnt      <= wcnt_d;
            tcnt      <= tcnt_d;
            sel       <= sel_d;
            rd        <= rd_d;
            uds_q     <= uds_d;
            lds_q     <= lds_d;
            step_cur  <= STEP_IN;
            step_prev <= step_cur;
        end
    end

    // Registered bus outputs, aligned with the state they describe.
    always_ff @(posedge CPUCLK_IN) begin
        if (RESET_IN) begin
            RESET <= 1'b1;
            HALT  <= 1'b1;
            RUN   <= 1'b0;
            DTACK <= 1'b0;
            BERR  <= 1'b0;
            CS    <= '0;
            OE    <= 1'b0;
            UWE   <= 1'b0;
            LWE   <= 1'b0;
        end else begin
            RESET <= reset_d;
            HALT  <= reset_d;
            RUN   <= run_d;
            DTACK <= dtack_d;
            BERR  <= berr_d;
            CS    <= cs_d;
            OE    <= oe_d;
            UWE   <= uwe_d;
            LWE   <= lwe_d;
        end
    end

endmodule
